// File: rtl/id_issue_pkg.sv
// id_issue_pkg: shared constants and decode helpers for the decode/issue stage.
//   - datapath width, register count, instruction field positions
//   - opcode values 0..10 and the 3-bit ALU op codes
//   - ctrl_t: per-opcode control bundle produced by decode()
//   - sext4/zext4: imm4 extension helpers
package id_issue_pkg;

    localparam int DSIZE = 16;
    localparam int NREG  = 16;
    localparam int AW    = 4;

    // Instruction fields: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_COM = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    localparam logic [3:0] OPC_ADD = 4'd0;
    localparam logic [3:0] OPC_SUB = 4'd1;
    localparam logic [3:0] OPC_AND = 4'd2;
    localparam logic [3:0] OPC_XOR = 4'd3;
    localparam logic [3:0] OPC_COM = 4'd4;
    localparam logic [3:0] OPC_MUL = 4'd5;
    localparam logic [3:0] OPC_SLL = 4'd6;
    localparam logic [3:0] OPC_SRL = 4'd7;
    localparam logic [3:0] OPC_LW  = 4'd8;
    localparam logic [3:0] OPC_SW  = 4'd9;
    localparam logic [3:0] OPC_BEQ = 4'd10;

    // Which field feeds read port 2 (NONE = port 2 not a real source)
    typedef enum logic [1:0] {SRC2_NONE, SRC2_RT, SRC2_RD, SRC2_RS} src2_t;
    typedef enum logic [1:0] {B_ZERO, B_REG, B_SEXT} b_sel_t;
    typedef enum logic [1:0] {IMM_ZERO, IMM_ZEXT, IMM_SEXT} imm_sel_t;

    typedef struct packed {
        logic [2:0] alu;
        logic       use1;     // read port 1 is a real source
        logic       src1_rd;  // read port 1 addresses rd instead of rs
        src2_t      src2;
        b_sel_t     b_sel;
        imm_sel_t   imm_sel;
        logic       sdata_en; // store data comes from read port 2
        logic       dest;     // instruction names rd as a destination
        logic       mrd;
        logic       mwr;
        logic       br;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [3:0] opc);
        ctrl_t c;
        c = '0;
        if (opc <= OPC_SRL) begin
            // ALU opcodes 0..7 share their encoding with the ALU op codes
            c.alu  = opc[2:0];
            c.use1 = 1'b1;
            c.dest = 1'b1;
            if (opc == OPC_SLL || opc == OPC_SRL) begin
                c.imm_sel = IMM_ZEXT;
            end else begin
                c.src2  = SRC2_RT;
                c.b_sel = B_REG;
            end
        end else begin
            case (opc)
                OPC_LW: begin
                    c.alu   = ALU_ADD;
                    c.use1  = 1'b1;
                    c.b_sel = B_SEXT;
                    c.dest  = 1'b1;
                    c.mrd   = 1'b1;
                end
                OPC_SW: begin
                    c.alu      = ALU_ADD;
                    c.use1     = 1'b1;
                    c.src2     = SRC2_RD;
                    c.b_sel    = B_SEXT;
                    c.sdata_en = 1'b1;
                    c.mwr      = 1'b1;
                end
                OPC_BEQ: begin
                    c.alu     = ALU_SUB;
                    c.use1    = 1'b1;
                    c.src1_rd = 1'b1;
                    c.src2    = SRC2_RS;
                    c.b_sel   = B_REG;
                    c.imm_sel = IMM_SEXT;
                    c.br      = 1'b1;
                end
                default: ; // 11..15 issue as a NOP
            endcase
        end
        return c;
    endfunction

    function automatic logic [DSIZE-1:0] sext4(input logic [3:0] imm);
        return {{(DSIZE-4){imm[3]}}, imm};
    endfunction

    function automatic logic [DSIZE-1:0] zext4(input logic [3:0] imm);
        return {{(DSIZE-4){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register 2-bit pending-write counters.
//   clk, rst              clock, synchronous active-high reset
//   inc_en/inc_addr       an instruction writing inc_addr issues
//   dec_en/dec_addr       writeback retires a write to dec_addr
//   fdec_en/fdec_addr     a flushed, unconsumed handoff retires its write
//   src1, src2, dst       addresses to look up
//   busy1, busy2          source has an outstanding write (a hazard)
//   full                  dst counter is saturated at 3
// Optional ID_WB_FWD_EN: a source whose only outstanding write is being
// written back this cycle is not reported busy.
import id_issue_pkg::*;

module id_scoreboard (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_en,
    input  logic [AW-1:0] inc_addr,
    input  logic          dec_en,
    input  logic [AW-1:0] dec_addr,
    input  logic          fdec_en,
    input  logic [AW-1:0] fdec_addr,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] src2,
    input  logic [AW-1:0] dst,
    output logic          busy1,
    output logic          busy2,
    output logic          full
);

    logic [1:0] cnt      [NREG];
    logic [1:0] cnt_next [NREG];

    // NOTE: every variable an always_comb writes gets a value on every path
    // (here, first statement of the loop body) so no latch is inferred.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_next[r] = cnt[r];
            if (inc_en && inc_addr == AW'(r)) begin
                cnt_next[r] = cnt_next[r] + 2'd1;
            end
            // A writeback to an idle register is stale and ignored
            if (dec_en && dec_addr == AW'(r) && cnt[r] != 2'd0) begin
                cnt_next[r] = cnt_next[r] - 2'd1;
            end
            if (fdec_en && fdec_addr == AW'(r) && cnt_next[r] != 2'd0) begin
                cnt_next[r] = cnt_next[r] - 2'd1;
            end
            if (r == 0) begin
                cnt_next[r] = 2'd0;
            end
        end
    end

    // NOTE: these counters are a small flop array, not a RAM, so they are
    // cleared in reset; a stale count would stall issue forever.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst) begin
                cnt[r] <= 2'd0;
            end else begin
                cnt[r] <= cnt_next[r];
            end
        end
    end

`ifdef ID_WB_FWD_EN
    always_comb begin
        busy1 = (cnt[src1] != 2'd0) &&
                !(cnt[src1] == 2'd1 && dec_en && dec_addr == src1);
        busy2 = (cnt[src2] != 2'd0) &&
                !(cnt[src2] == 2'd1 && dec_en && dec_addr == src2);
    end
`else
    always_comb begin
        busy1 = (cnt[src1] != 2'd0);
        busy2 = (cnt[src2] != 2'd0);
    end
`endif

    assign full = (cnt[dst] == 2'd3);

endmodule

// File: rtl/id_issue.sv
// id_issue: decode-and-issue stage between fetch and execute.
//   clk, rst                       clock, synchronous active-high reset
//   if_valid, if_inst, id_ready    fetch handshake (accept = valid && ready)
//   rf_raddr1/2, rf_rdata1/2       combinational register file read
//   wb_wen, wb_addr, wb_data       writeback, clears pending writes
//   flush                          kill the handoff and the current if_inst
//   ex_ready, ex_valid             execute handshake
//   ex_a, ex_b, ex_imm, ex_sdata   operands, immediate, store data
//   ex_op, ex_rd, ex_wen, ex_mrd, ex_mwr, ex_br   controls
// Optional ID_WB_FWD_EN: forward wb_data into operands so a stalled
// instruction issues in the writeback cycle.
import id_issue_pkg::*;

module id_issue (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [15:0]      if_inst,
    output logic             id_ready,
    output logic [AW-1:0]    rf_raddr1,
    output logic [AW-1:0]    rf_raddr2,
    input  logic [DSIZE-1:0] rf_rdata1,
    input  logic [DSIZE-1:0] rf_rdata2,
    input  logic             wb_wen,
    input  logic [AW-1:0]    wb_addr,
    input  logic [DSIZE-1:0] wb_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [DSIZE-1:0] ex_imm,
    output logic [DSIZE-1:0] ex_sdata,
    output logic [2:0]       ex_op,
    output logic [AW-1:0]    ex_rd,
    output logic             ex_wen,
    output logic             ex_mrd,
    output logic             ex_mwr,
    output logic             ex_br
);

    logic [3:0]    opc;
    logic [AW-1:0] rd, rs, rt;
    ctrl_t         c;
    logic          dec_wen;
    logic [DSIZE-1:0] op1, op2, op_a, op_b, op_imm, op_sdata;
    logic          busy1, busy2, full, hazard, accept, fdec_en;

    assign opc = if_inst[OPC_LSB +: 4];
    assign rd  = if_inst[RD_LSB +: AW];
    assign rs  = if_inst[RS_LSB +: AW];
    assign rt  = if_inst[RT_LSB +: AW];
    assign c   = decode(opc);

    // Writes to r0 are dropped here so r0 is never marked pending
    assign dec_wen = c.dest && (rd != '0);

    assign rf_raddr1 = c.src1_rd ? rd : rs;
    assign rf_raddr2 = (c.src2 == SRC2_RD) ? rd :
                       (c.src2 == SRC2_RS) ? rs : rt;

`ifdef ID_WB_FWD_EN
    always_comb begin
        op1 = rf_rdata1;
        op2 = rf_rdata2;
        if (wb_wen && wb_addr == rf_raddr1 && rf_raddr1 != '0) op1 = wb_data;
        if (wb_wen && wb_addr == rf_raddr2 && rf_raddr2 != '0) op2 = wb_data;
    end
`else
    logic wb_data_unused;
    assign wb_data_unused = ^wb_data;
    assign op1 = rf_rdata1;
    assign op2 = rf_rdata2;
`endif

    always_comb begin
        op_a = c.use1 ? op1 : '0;
        case (c.b_sel)
            B_REG:   op_b = op2;
            B_SEXT:  op_b = sext4(rt);
            default: op_b = '0;
        endcase
        case (c.imm_sel)
            IMM_ZEXT: op_imm = zext4(rt);
            IMM_SEXT: op_imm = sext4(rt);
            default:  op_imm = '0;
        endcase
        op_sdata = c.sdata_en ? op2 : '0;
    end

    id_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (accept && dec_wen),
        .inc_addr  (rd),
        .dec_en    (wb_wen),
        .dec_addr  (wb_addr),
        .fdec_en   (fdec_en),
        .fdec_addr (ex_rd),
        .src1      (rf_raddr1),
        .src2      (rf_raddr2),
        .dst       (rd),
        .busy1     (busy1),
        .busy2     (busy2),
        .full      (full)
    );

    assign hazard = (c.use1 && busy1) ||
                    ((c.src2 != SRC2_NONE) && busy2) ||
                    (dec_wen && full);

    assign id_ready = !rst && !hazard && (!ex_valid || ex_ready) && !flush;
    assign accept   = if_valid && id_ready;

    // A flushed handoff that execute has not taken will never write back
    assign fdec_en = flush && ex_valid && ex_wen && !ex_ready;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_sdata <= '0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_wen   <= 1'b0;
            ex_mrd   <= 1'b0;
            ex_mwr   <= 1'b0;
            ex_br    <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_a     <= op_a;
            ex_b     <= op_b;
            ex_imm   <= op_imm;
            ex_sdata <= op_sdata;
            ex_op    <= c.alu;
            ex_rd    <= c.dest ? rd : '0;
            ex_wen   <= dec_wen;
            ex_mrd   <= c.mrd;
            ex_mwr   <= c.mwr;
            ex_br    <= c.br;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_issue.sv
// tb_id_issue: directed bench for id_issue with a behavioural register file.
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_inst;
    logic        id_ready;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic        wb_wen;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [15:0] ex_a, ex_b, ex_imm, ex_sdata;
    logic [2:0]  ex_op;
    logic [3:0]  ex_rd;
    logic        ex_wen, ex_mrd, ex_mwr, ex_br;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_issue dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_inst(if_inst), .id_ready(id_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_sdata(ex_sdata),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_mrd(ex_mrd), .ex_mwr(ex_mwr), .ex_br(ex_br)
    );

    // Register file model: reset loads known contents, writeback updates it
    logic [15:0] rf [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0100 + 16'(i);
            rf[1] <= 16'h0005;
            rf[2] <= 16'h0007;
            rf[3] <= 16'h00AA;
            rf[4] <= 16'h1234;
            rf[5] <= 16'h0F0F;
        end else if (wb_wen && wb_addr != 4'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end
    assign rf_rdata1 = (rf_raddr1 == 4'd0) ? 16'd0 : rf[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 4'd0) ? 16'd0 : rf[rf_raddr2];

    typedef struct {
        logic [15:0] inst;
        logic [2:0]  op;
        logic [15:0] a, b, imm, sdata;
        logic [3:0]  rd;
        logic        wen, mrd, mwr, br;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [79:0] dut_outs();
        return {5'b0, ex_op, ex_a, ex_b, ex_imm, ex_sdata, ex_rd,
                ex_wen, ex_mrd, ex_mwr, ex_br};
    endfunction

    function automatic logic [79:0] pack_exp(input vec_t v);
        return {5'b0, v.op, v.a, v.b, v.imm, v.sdata, v.rd,
                v.wen, v.mrd, v.mwr, v.br};
    endfunction

    task automatic check(input string name, input logic [79:0] act,
                         input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one instruction and wait (bounded) for acceptance.
    // Returns just after the accepting edge with if_valid dropped.
    task automatic present(input logic [15:0] inst, output logic ok,
                           output int stalls);
        @(negedge clk);
        if_valid = 1'b1;
        if_inst  = inst;
        ok       = 1'b0;
        stalls   = 0;
        while (1) begin
            #1;
            ok = id_ready;
            @(posedge clk);
            if (ok || stalls >= 20) break;
            stalls++;
            @(negedge clk);
        end
        #1;
        if_valid = 1'b0;
    endtask

    task automatic wb(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        wb_wen  = 1'b1;
        wb_addr = addr;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_wen = 1'b0;
    endtask

    logic ok;
    int   st;

    initial begin
        vecs[0]  = '{16'h0312, 3'd0, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h1821, 3'd1, 16'h0007, 16'h0005, 16'h0000, 16'h0000, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h2945, 3'd2, 16'h1234, 16'h0F0F, 16'h0000, 16'h0000, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h3A54, 3'd3, 16'h0F0F, 16'h1234, 16'h0000, 16'h0000, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h4B10, 3'd4, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h5C22, 3'd5, 16'h0007, 16'h0007, 16'h0000, 16'h0000, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h6413, 3'd6, 16'h0005, 16'h0000, 16'h0003, 16'h0000, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h7D5F, 3'd7, 16'h0F0F, 16'h0000, 16'h000F, 16'h0000, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h821F, 3'd0, 16'h0005, 16'hFFFF, 16'h0000, 16'h0000, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'h9512, 3'd0, 16'h0005, 16'h0002, 16'h0000, 16'h0F0F, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'hA12E, 3'd1, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'hF123, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{16'h0012, 3'd0, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; if_valid = 1'b1; if_inst = 16'h0312;
        wb_wen = 1'b0; wb_addr = 4'd0; wb_data = 16'd0;
        flush = 1'b0; ex_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_id_ready", id_ready, 0);
        check("reset_ex_valid", ex_valid, 0);
        check("reset_ex_outs", dut_outs(), 80'd0);
        if_valid = 1'b0;
        rst = 1'b0;

        // Decode table, scoreboard drained after each write
        for (int i = 0; i < 13; i++) begin
            present(vecs[i].inst, ok, st);
            check($sformatf("vec%0d_accept", i), ok, 1);
            check($sformatf("vec%0d_stalls", i), st, 0);
            check($sformatf("vec%0d_valid", i), ex_valid, 1);
            check($sformatf("vec%0d_outs", i), dut_outs(), pack_exp(vecs[i]));
            if (vecs[i].wen) wb(vecs[i].rd, rf[vecs[i].rd]);
        end

        // RAW hazard: ADD r3,r1,r2 then SUB r5,r3,r1
        present(16'h0312, ok, st);
        check("raw_first_accept", ok, 1);
        @(negedge clk);
        if_valid = 1'b1; if_inst = 16'h1531;
        #1 check("raw_stall0", id_ready, 0);
        @(negedge clk);
        #1 check("raw_stall1", id_ready, 0);
        @(negedge clk);
        wb_wen = 1'b1; wb_addr = 4'd3; wb_data = 16'd12;
`ifdef ID_WB_FWD_EN
        #1 check("raw_fwd_ready", id_ready, 1);
        @(posedge clk);
        #1 wb_wen = 1'b0;
`else
        #1 check("raw_wb_cycle_ready", id_ready, 0);
        @(posedge clk);
        #1 wb_wen = 1'b0;
        @(negedge clk);
        #1 check("raw_after_wb_ready", id_ready, 1);
        @(posedge clk);
        #1;
`endif
        if_valid = 1'b0;
        check("raw_valid", ex_valid, 1);
        check("raw_ex_a", ex_a, 16'd12);
        check("raw_ex_b", ex_b, 16'd5);
        check("raw_ex_rd", ex_rd, 4'd5);
        wb(4'd5, 16'h0F0F);

        // Backpressure: ex_ready low for 3 cycles
        ex_ready = 1'b0;
        present(16'h3A54, ok, st);
        check("bp_first_accept", ok, 1);
        @(negedge clk);
        if_valid = 1'b1; if_inst = 16'h0B12;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_hold%0d_ready", k), id_ready, 0);
            check($sformatf("bp_hold%0d_valid", k), ex_valid, 1);
            check($sformatf("bp_hold%0d_outs", k), dut_outs(), pack_exp(vecs[3]));
            @(negedge clk);
        end
        ex_ready = 1'b1;
        #1 check("bp_resume_ready", id_ready, 1);
        @(posedge clk);
        #1 if_valid = 1'b0;
        check("bp_resume_valid", ex_valid, 1);
        check("bp_resume_ex_a", ex_a, 16'h0005);
        check("bp_resume_ex_rd", ex_rd, 4'd11);
        wb(4'd10, rf[10]);
        wb(4'd11, rf[11]);

        // Flush an unconsumed ADD r6; r6 must no longer be pending
        ex_ready = 1'b0;
        present(16'h0612, ok, st);
        check("flush_first_accept", ok, 1);
        @(negedge clk);
        flush = 1'b1; if_valid = 1'b1; if_inst = 16'h0761;
        #1 check("flush_cycle_ready", id_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_ex_valid", ex_valid, 0);
        @(negedge clk);
        #1 check("flush_r6_no_stall", id_ready, 1);
        @(posedge clk);
        #1 if_valid = 1'b0;
        check("flush_next_ex_a", ex_a, 16'h0106);
        ex_ready = 1'b1;
        wb(4'd7, rf[7]);

        // r0 as a source never stalls and reads zero
        present(16'h0901, ok, st);
        check("r0_read_stalls", st, 0);
        check("r0_read_ex_a", ex_a, 16'd0);
        check("r0_read_ex_b", ex_b, 16'd5);
        wb(4'd9, rf[9]);

        // Reset mid-stall drops the held instruction and the scoreboard
        present(16'h0C12, ok, st);
        check("rst_first_accept", ok, 1);
        @(negedge clk);
        if_valid = 1'b1; if_inst = 16'h0DC1;
        #1 check("rst_pre_stall", id_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_mid_ready", id_ready, 0);
        @(posedge clk);
        #1;
        check("rst_mid_valid", ex_valid, 0);
        check("rst_mid_outs", dut_outs(), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_replay_ready", id_ready, 1);
        @(posedge clk);
        #1 if_valid = 1'b0;
        check("rst_replay_ex_a", ex_a, 16'h010C);
        check("rst_replay_ex_rd", ex_rd, 4'd13);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
